// File: rtl/micro_regfile_sb.sv
// micro_regfile_sb
//   General-purpose register file with a write-pending scoreboard.
//   NRD combinational read ports with write-through bypass, one synchronous
//   write port, one busy bit per register set on issue and cleared on
//   writeback. Register 0 can be hardwired to zero (ZERO_REG=1).
//
// Ports
//   clk1      in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   rd_addr   in   NRD*AW     packed read addresses, port i at [i*AW +: AW]
//   rd_data   out  NRD*DATA_W packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy   out  NRD        addressed register has a pending write
//   wr_en     in   writeback strobe
//   wr_addr   in   AW         writeback destination
//   wr_data   in   DATA_W     writeback value
//   iss_en    in   issue strobe, reserves a destination
//   iss_addr  in   AW         register to mark busy
//   busy_all  out  NREGS      registered scoreboard vector
module micro_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [NREGS-1:0]      busy_all
);

  localparam logic [AW-1:0] ADDR_ZERO = '0;
  localparam logic          HAS_ZERO  = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [NREGS-1:0]  w_busy_nxt;

  // Writes and issues targeting the hardwired zero register are dropped.
  assign w_wr_ok  = wr_en  && !(HAS_ZERO && (wr_addr  == ADDR_ZERO));
  assign w_iss_ok = iss_en && !(HAS_ZERO && (iss_addr == ADDR_ZERO));

  // Clear is applied before set so a same-address issue keeps the bit high:
  // the newly issued producer owns the register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (w_iss_ok) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports: zero register overrides bypass, bypass overrides storage.
  // rd_busy ignores a same-cycle issue; it only changes state after the edge.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    logic          w_zero;

    assign w_ra   = rd_addr[g*AW +: AW];
    assign w_hit  = wr_en && (wr_addr == w_ra);
    assign w_zero = HAS_ZERO && (w_ra == ADDR_ZERO);

    assign rd_data[g*DATA_W +: DATA_W] = w_zero ? '0 :
                                         w_hit  ? wr_data :
                                                  r_regs[w_ra];
    assign rd_busy[g] = !w_zero && !w_hit && r_busy[w_ra];
  end

  assign busy_all = r_busy;

endmodule

// File: tb/tb_micro_regfile_sb.sv
module tb_micro_regfile_sb;

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  // DUT A: default configuration (32x32, 2 read ports, zero register)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_iss_en;
  logic [4:0]  a_iss_addr;
  logic [31:0] a_busy_all;

  // DUT B: 8x16, 4 read ports, no zero register
  logic [11:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_iss_en;
  logic [2:0]  b_iss_addr;
  logic [7:0]  b_busy_all;

  micro_regfile_sb u_dut_a (
    .clk1(clk1), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .busy_all(a_busy_all)
  );

  micro_regfile_sb #(.DATA_W(16), .NREGS(8), .NRD(4), .ZERO_REG(0)) u_dut_b (
    .clk1(clk1), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .busy_all(b_busy_all)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays of register contents and pending flags.
  logic [31:0] ma_regs [32];
  bit          ma_busy [32];
  logic [15:0] mb_regs [8];
  bit          mb_busy [8];

  task automatic clear_models();
    for (int k = 0; k < 32; k++) begin ma_regs[k] = '0; ma_busy[k] = 0; end
    for (int k = 0; k < 8; k++)  begin mb_regs[k] = '0; mb_busy[k] = 0; end
  endtask

  // One clock: apply architectural effects of the inputs present at the edge.
  task automatic step();
    @(posedge clk1);
    if (rst_n) begin
      if (a_wr_en && a_wr_addr != 0) begin
        ma_regs[a_wr_addr] = a_wr_data;
        ma_busy[a_wr_addr] = 0;
      end
      if (a_iss_en && a_iss_addr != 0) ma_busy[a_iss_addr] = 1;
      if (b_wr_en) begin
        mb_regs[b_wr_addr] = b_wr_data;
        mb_busy[b_wr_addr] = 0;
      end
      if (b_iss_en) mb_busy[b_iss_addr] = 1;
    end
    #1;
  endtask

  function automatic logic [31:0] a_exp_data(logic [4:0] ad);
    if (ad == 0) return '0;
    if (a_wr_en && a_wr_addr == ad) return a_wr_data;
    return ma_regs[ad];
  endfunction

  function automatic logic a_exp_busy(logic [4:0] ad);
    if (ad == 0) return 1'b0;
    if (a_wr_en && a_wr_addr == ad) return 1'b0;
    return ma_busy[ad];
  endfunction

  function automatic logic [31:0] a_exp_all();
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = ma_busy[k];
    return v;
  endfunction

  function automatic logic [15:0] b_exp_data(logic [2:0] ad);
    if (b_wr_en && b_wr_addr == ad) return b_wr_data;
    return mb_regs[ad];
  endfunction

  function automatic logic b_exp_busy(logic [2:0] ad);
    if (b_wr_en && b_wr_addr == ad) return 1'b0;
    return mb_busy[ad];
  endfunction

  function automatic logic [7:0] b_exp_all();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mb_busy[k];
    return v;
  endfunction

  task automatic idle_inputs();
    a_wr_en = 0; a_iss_en = 0; b_wr_en = 0; b_iss_en = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_rd_addr = {5'd7, 5'd5}; a_wr_addr = 0; a_wr_data = 0; a_iss_addr = 0;
    b_rd_addr = 12'o7531; b_wr_addr = 0; b_wr_data = 0; b_iss_addr = 0;
    idle_inputs();
    clear_models();
    #12;
    total++; if (a_busy_all !== 32'h0) begin bad++; $display("FAIL reset_a_busy_all got=%0h exp=0", a_busy_all); end
    total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL reset_a_rd_data got=%0h exp=0", a_rd_data); end
    total++; if (b_busy_all !== 8'h0 || b_rd_data !== 64'h0 || b_rd_busy !== 4'h0) begin
      bad++; $display("FAIL reset_b got busy_all=%0h data=%0h busy=%0h exp=0", b_busy_all, b_rd_data, b_rd_busy);
    end
    rst_n = 1;
    step();
    // Write R5 and issue R7, then reset mid-cycle.
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'h1234;
    a_iss_en = 1; a_iss_addr = 7;
    step();
    idle_inputs();
    #1;
    total++; if (a_rd_data !== {32'h0, 32'h1234} || a_busy_all !== 32'h80) begin
      bad++; $display("FAIL pre_reset got data=%0h busy_all=%0h exp data=1234 busy_all=80", a_rd_data, a_busy_all);
    end
    #2;
    rst_n = 0;
    clear_models();
    #1;
    total++; if (a_busy_all !== 32'h0 || a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      bad++; $display("FAIL async_reset got busy_all=%0h data=%0h busy=%0h exp=0", a_busy_all, a_rd_data, a_rd_busy);
    end
    // A write strobe during reset must not land.
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'hDEAD_BEEF;
    step();
    a_wr_en = 0;
    #1;
    rst_n = 1;
    a_rd_addr = {5'd9, 5'd5};
    #1;
    total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL reset_discard got=%0h exp=0", a_rd_data); end
  endtask

  task automatic test_write_read();
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 32'h0000_000A; a_rd_addr = 0;
    step();
    a_wr_en = 0; a_rd_addr = {5'd0, 5'd1};
    #1;
    total++; if (a_rd_data[31:0] !== 32'hA || a_rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL write_read got data=%0h busy=%0b exp data=a busy=0", a_rd_data[31:0], a_rd_busy[0]);
    end
  endtask

  task automatic test_bypass();
    a_iss_en = 1; a_iss_addr = 3;
    step();
    a_iss_en = 0;
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h19; a_rd_addr = {5'd3, 5'd1};
    #1;
    total++; if (a_rd_data[63:32] !== 32'h19 || a_rd_busy[1] !== 1'b0) begin
      bad++; $display("FAIL bypass got data=%0h busy=%0b exp data=19 busy=0", a_rd_data[63:32], a_rd_busy[1]);
    end
    total++; if (a_busy_all[3] !== 1'b1) begin bad++; $display("FAIL bypass_busy_all got=%0b exp=1", a_busy_all[3]); end
    step();
    a_wr_en = 0;
    #1;
    total++; if (a_busy_all[3] !== 1'b0 || a_rd_data[63:32] !== 32'h19) begin
      bad++; $display("FAIL bypass_after got busy=%0b data=%0h exp busy=0 data=19", a_busy_all[3], a_rd_data[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    a_iss_en = 1; a_iss_addr = 4; a_rd_addr = {5'd0, 5'd4};
    #1;
    total++; if (a_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL issue_same_cycle got=%0b exp=0", a_rd_busy[0]); end
    step();
    a_iss_en = 0;
    #1;
    total++; if (a_rd_busy[0] !== 1'b1 || a_busy_all[4] !== 1'b1) begin
      bad++; $display("FAIL issue_busy got rd_busy=%0b busy_all4=%0b exp 1 1", a_rd_busy[0], a_busy_all[4]);
    end
    step();
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 32'h1E;
    #1;
    total++; if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h1E) begin
      bad++; $display("FAIL writeback got busy=%0b data=%0h exp busy=0 data=1e", a_rd_busy[0], a_rd_data[31:0]);
    end
    step();
    a_wr_en = 0;
    #1;
    total++; if (a_busy_all[4] !== 1'b0 || a_rd_data[31:0] !== 32'h1E) begin
      bad++; $display("FAIL writeback_after got busy_all4=%0b data=%0h exp 0 1e", a_busy_all[4], a_rd_data[31:0]);
    end
  endtask

  task automatic test_same_addr();
    a_wr_en = 1; a_wr_addr = 6; a_wr_data = 32'h55;
    a_iss_en = 1; a_iss_addr = 6;
    step();
    idle_inputs();
    a_rd_addr = {5'd6, 5'd6};
    #1;
    total++; if (a_busy_all[6] !== 1'b1 || a_rd_busy !== 2'b11) begin
      bad++; $display("FAIL set_wins got busy_all6=%0b rd_busy=%0b exp 1 11", a_busy_all[6], a_rd_busy);
    end
    total++; if (a_rd_data !== {32'h55, 32'h55}) begin bad++; $display("FAIL same_addr_data got=%0h exp=55 on both", a_rd_data); end
  endtask

  task automatic test_zero_reg();
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'hFFFF_FFFF;
    a_iss_en = 1; a_iss_addr = 0; a_rd_addr = {5'd0, 5'd0};
    #1;
    total++; if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      bad++; $display("FAIL zero_over_bypass got data=%0h busy=%0b exp 0 0", a_rd_data, a_rd_busy);
    end
    step();
    idle_inputs();
    #1;
    total++; if (a_rd_data !== 64'h0 || a_busy_all[0] !== 1'b0) begin
      bad++; $display("FAIL zero_reg got data=%0h busy_all0=%0b exp 0 0", a_rd_data, a_busy_all[0]);
    end
  endtask

  task automatic test_random_a();
    for (int n = 0; n < 300; n++) begin
      a_wr_en    = 1'($urandom_range(0, 1));
      a_wr_addr  = 5'($urandom_range(0, 9));
      a_wr_data  = $urandom();
      a_iss_en   = 1'($urandom_range(0, 1));
      a_iss_addr = 5'($urandom_range(0, 9));
      a_rd_addr  = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 31))};
      #1;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] ad;
        ad = a_rd_addr[p*5 +: 5];
        total++; if (a_rd_data[p*32 +: 32] !== a_exp_data(ad)) begin
          bad++; $display("FAIL rand_a_data port=%0d addr=%0d got=%0h exp=%0h", p, ad, a_rd_data[p*32 +: 32], a_exp_data(ad));
        end
        total++; if (a_rd_busy[p] !== a_exp_busy(ad)) begin
          bad++; $display("FAIL rand_a_busy port=%0d addr=%0d got=%0b exp=%0b", p, ad, a_rd_busy[p], a_exp_busy(ad));
        end
      end
      total++; if (a_busy_all !== a_exp_all()) begin
        bad++; $display("FAIL rand_a_busy_all got=%0h exp=%0h", a_busy_all, a_exp_all());
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_config_b();
    b_wr_en = 1; b_wr_addr = 0; b_wr_data = 16'hFFFF;
    b_iss_en = 1; b_iss_addr = 0; b_rd_addr = 12'h000;
    #1;
    total++; if (b_rd_data !== {4{16'hFFFF}} || b_rd_busy !== 4'h0) begin
      bad++; $display("FAIL b_r0_bypass got data=%0h busy=%0h exp ffff x4 busy 0", b_rd_data, b_rd_busy);
    end
    step();
    idle_inputs();
    #1;
    total++; if (b_rd_data !== {4{16'hFFFF}} || b_rd_busy !== 4'hF || b_busy_all[0] !== 1'b1) begin
      bad++; $display("FAIL b_r0_stored got data=%0h busy=%0h busy_all0=%0b exp ffff x4 f 1", b_rd_data, b_rd_busy, b_busy_all[0]);
    end
    for (int n = 0; n < 200; n++) begin
      b_wr_en    = 1'($urandom_range(0, 1));
      b_wr_addr  = 3'($urandom_range(0, 7));
      b_wr_data  = 16'($urandom());
      b_iss_en   = 1'($urandom_range(0, 1));
      b_iss_addr = 3'($urandom_range(0, 7));
      b_rd_addr  = 12'($urandom());
      #1;
      for (int p = 0; p < 4; p++) begin
        logic [2:0] ad;
        ad = b_rd_addr[p*3 +: 3];
        total++; if (b_rd_data[p*16 +: 16] !== b_exp_data(ad) || b_rd_busy[p] !== b_exp_busy(ad)) begin
          bad++; $display("FAIL rand_b port=%0d addr=%0d got data=%0h busy=%0b exp data=%0h busy=%0b",
                          p, ad, b_rd_data[p*16 +: 16], b_rd_busy[p], b_exp_data(ad), b_exp_busy(ad));
        end
      end
      total++; if (b_busy_all !== b_exp_all()) begin
        bad++; $display("FAIL rand_b_busy_all got=%0h exp=%0h", b_busy_all, b_exp_all());
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_same_addr();
    test_zero_reg();
    test_random_a();
    test_config_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/micro_regfile_sb.md
Name: micro_regfile_sb

Overview:
- Parametrised general-purpose register file with an integrated write-pending scoreboard, for the next-generation pipelined micro32-class core.
- Provides NRD combinational read ports and one synchronous write port, with write-through bypass and a hardwired zero register.
- Tracks one busy bit per register so decode can stall on RAW hazards.
- Replaces the fixed 32x32 array that currently sits inside the core.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width; derived, do not override.
- NRD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1 register 0 reads as 0 and is never written or marked busy.

Ports:
- clk1  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*DATA_W  packed read data; port i occupies bits [i*DATA_W +: DATA_W].
- rd_busy  out  NRD  per-port flag: the addressed register has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  DATA_W  writeback value.
- iss_en  in  1  issue strobe; reserves a destination register.
- iss_addr  in  AW  register to mark busy.
- busy_all  out  NREGS  full scoreboard vector, for debug and bench checks.

Behaviour:
- Reset: asserting rst_n low immediately clears every register to 0 and every busy bit to 0, regardless of clk1.
  - rd_data then reads all zeros and rd_busy and busy_all read 0.
  - Reset asserted mid-operation discards pending writes and reservations in the same instant; no write completes that cycle.
- Write: on a rising clk1 edge with wr_en=1, reg[wr_addr] <= wr_data, and busy[wr_addr] clears unless it is re-issued that same cycle (see below).
  - Latency: the stored value is visible from the next cycle.
- Read: combinational.
  - rd_data[i] = reg[rd_addr[i]], except for the two overrides below.
  - Bypass: if wr_en=1 and wr_addr==rd_addr[i], rd_data[i]=wr_data in the same cycle. This is write-through, so the read returns the new value.
  - Zero register: if ZERO_REG=1 and rd_addr[i]==0, rd_data[i]=0 and rd_busy[i]=0. This overrides the bypass.
- rd_busy[i]:
  - Equals busy[rd_addr[i]], except it reads 0 when wr_en=1 and wr_addr==rd_addr[i]. The bypass resolves the hazard that cycle.
  - Exception: if iss_en=1 and iss_addr==rd_addr[i] in the same cycle, rd_busy[i] still reads from current state only; issue affects the next cycle.
- Issue: on a rising edge with iss_en=1, busy[iss_addr] <= 1.
- Simultaneous write and issue:
  - Same address: set wins and busy stays 1. The new producer owns the register, and the data write still occurs.
  - Different addresses: both take effect.
- Writes and issues to address 0 with ZERO_REG=1 are ignored.
  - With ZERO_REG=0, register 0 behaves like any other register.
- Addresses are always in range by construction, since NREGS is a power of two. No wrap or error handling is needed.
- A write to a register that is not busy is legal: data updates and the busy bit stays 0.
- Repeated issue to an already-busy register is legal: busy stays 1. There is a single bit, not a counter.
- Multiple read ports addressing the same register all return the same value and busy flag.
- busy_all reflects registered state only (no bypass).
- No X may reach rd_data after reset.

Test Plan:
- Reset check: drive rst_n low mid-cycle after writing R5=0x1234 and issuing R7 -> immediately all rd_data=0 and busy_all=0; R5 reads 0 after release.
- Write then read: write R1=0x0000000A, next cycle read rd_addr port0=1 -> rd_data=0x0000000A and rd_busy=0.
- Bypass: same cycle wr_en=1, wr_addr=3, wr_data=0x19, rd_addr port1=3 -> rd_data port1=0x19 and rd_busy[1]=0 combinationally.
- Scoreboard:
  - Issue R4 -> next cycle rd_busy=1 when reading R4 and busy_all[4]=1.
  - Writeback R4=0x1E two cycles later -> that cycle rd_busy=0 and rd_data=0x1E; busy_all[4]=0 after the edge.
- Simultaneous same-address write and issue on R6 (wr_data=0x55) -> after the edge reg6=0x55 and busy_all[6]=1.
- Zero register:
  - ZERO_REG=1: write R0=0xFFFFFFFF and issue R0 -> R0 reads 0 and busy_all[0]=0.
  - Rerun with ZERO_REG=0 and NRD=4, DATA_W=16, NREGS=8 -> R0 reads 0xFFFF and all four ports agree.
